bram_capture_ctrl: RTL and testbench

- Sequences a single block RAM used as a capture buffer for filter output samples.
- Capture side: arms, waits for a trigger, then writes a programmed number of strobed samples at consecutive addresses from 0.
- Readout side: dumps the stored samples in address order over a valid/ready stream.
- Sits between the filter datapath and the block RAM; drives the RAM's write port, read port and read enable.

---
 rtl/bram_capture_ctrl.sv | 160 ++++++++++++++++
 tb/tb_bram_capture_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_capture_ctrl.sv
// bram_capture_ctrl
//   Sequences one block RAM used as a capture buffer for filter output samples.
//   Capture: arm -> wait for trigger -> write len strobed samples from address 0.
//   Readout: dump stored samples in address order over a valid/ready stream,
//   one word per three cycles (issue read, wait for RAM, hold for handshake).
//
// Ports
//   clock, i_reset          clock (rising edge), async active-low reset
//   i_arm, i_abort, i_dump  one-cycle control pulses (abort > arm > others)
//   i_trigger               capture start, looked at only while ARMED
//   i_capture_len           sample count, latched on accepted arm (0 or >depth -> depth)
//   i_sample_valid/i_sample filter sample stream
//   o_ram_we/_wr_addr/_wr_data   RAM write port
//   o_ram_re/_rd_addr, i_ram_rd_data  RAM read port, 1-cycle read latency
//   o_dump_data/_valid/_last, i_dump_ready  readout stream
//   o_busy, o_done, o_count, o_state  status / debug
module bram_capture_ctrl #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 32000,
  parameter int ADDR_W    = 16
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_arm,
  input  logic                 i_abort,
  input  logic                 i_trigger,
  input  logic [ADDR_W-1:0]    i_capture_len,
  input  logic                 i_sample_valid,
  input  logic [RAM_WIDTH-1:0] i_sample,
  input  logic                 i_dump,
  output logic [ADDR_W-1:0]    o_ram_wr_addr,
  output logic [RAM_WIDTH-1:0] o_ram_wr_data,
  output logic                 o_ram_we,
  output logic [ADDR_W-1:0]    o_ram_rd_addr,
  output logic                 o_ram_re,
  input  logic [RAM_WIDTH-1:0] i_ram_rd_data,
  output logic [RAM_WIDTH-1:0] o_dump_data,
  output logic                 o_dump_valid,
  input  logic                 i_dump_ready,
  output logic                 o_dump_last,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [ADDR_W-1:0]    o_count,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_CAPTURE  = 3'd2,
    S_DONE     = 3'd3,
    S_RD_ISSUE = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_RD_HOLD  = 3'd6
  } state_e;

  // Length is one bit wider than an address so a full-depth capture fits
  // even when RAM_DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(RAM_DEPTH);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;   // write address; also the sample count
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      len_q, len_d;
  logic [RAM_WIDTH-1:0] dump_data_q, dump_data_d;

  logic            we, last_wr, rd_last, accept;
  logic [ADDR_W:0] wr_cnt_inc, len_clamped;

  always_comb begin
    len_clamped = {1'b0, i_capture_len};
    if (i_capture_len == '0 || len_clamped > DEPTH_L) len_clamped = DEPTH_L;
  end

  // Abort suppresses the write in its own cycle.
  assign we         = i_sample_valid & ~i_abort &
                      ((state_q == S_CAPTURE) | ((state_q == S_ARMED) & i_trigger));
  assign wr_cnt_inc = {1'b0, wr_ptr_q} + (ADDR_W+1)'(1);
  assign last_wr    = we & (wr_cnt_inc == len_q);
  assign rd_last    = (rd_ptr_q == wr_ptr_q - ADDR_W'(1));
  assign accept     = (state_q == S_RD_HOLD) & i_dump_ready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    dump_data_d = dump_data_q;
    if (we) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (i_abort) begin
      state_d = S_IDLE;
    end else if (i_arm && (state_q == S_IDLE || state_q == S_DONE)) begin
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      len_d    = len_clamped;
    end else begin
      case (state_q)
        S_IDLE:     ;
        // A sample coincident with the trigger is already written; with
        // len==1 that single write completes the capture.
        S_ARMED:    if (i_trigger) state_d = last_wr ? S_DONE : S_CAPTURE;
        S_CAPTURE:  if (last_wr) state_d = S_DONE;
        S_DONE: begin
          if (i_dump) begin
            rd_ptr_d = '0;
            state_d  = S_RD_ISSUE;
          end
        end
        S_RD_ISSUE: state_d = S_RD_WAIT;
        S_RD_WAIT: begin
          dump_data_d = i_ram_rd_data;
          state_d     = S_RD_HOLD;
        end
        S_RD_HOLD: begin
          if (accept) begin
            if (rd_last) begin
              state_d = S_DONE;
            end else begin
              rd_ptr_d = rd_ptr_q + ADDR_W'(1);
              state_d  = S_RD_ISSUE;
            end
          end
        end
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      dump_data_q <= dump_data_d;
    end
  end

  assign o_ram_we      = we;
  assign o_ram_wr_addr = wr_ptr_q;
  assign o_ram_wr_data = i_sample;
  assign o_ram_re      = (state_q == S_RD_ISSUE);
  assign o_ram_rd_addr = rd_ptr_q;
  assign o_dump_data   = dump_data_q;
  assign o_dump_valid  = (state_q == S_RD_HOLD);
  assign o_dump_last   = o_dump_valid & rd_last;
  assign o_busy        = (state_q == S_ARMED) | (state_q == S_CAPTURE) |
                         (state_q == S_RD_ISSUE) | (state_q == S_RD_WAIT) |
                         (state_q == S_RD_HOLD);
  assign o_done        = (state_q == S_DONE);
  assign o_count       = wr_ptr_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Bench for bram_capture_ctrl: behavioural model of the capture/readout rules
// compared against the DUT every cycle, plus directed literal checks.
module tb_bram_capture_ctrl;
  localparam int RW = 32;
  localparam int RD = 32000;
  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_arm = 1'b0, i_abort = 1'b0, i_trigger = 1'b0, i_dump = 1'b0;
  logic [AW-1:0] i_capture_len = '0;
  logic          i_sample_valid = 1'b0;
  logic [RW-1:0] i_sample = '0;
  logic          i_dump_ready = 1'b0;
  logic [AW-1:0] o_ram_wr_addr, o_ram_rd_addr, o_count;
  logic [RW-1:0] o_ram_wr_data, o_dump_data;
  logic [RW-1:0] i_ram_rd_data = '0;
  logic          o_ram_we, o_ram_re, o_dump_valid, o_dump_last, o_busy, o_done;
  logic [2:0]    o_state;

  bram_capture_ctrl #(.RAM_WIDTH(RW), .RAM_DEPTH(RD), .ADDR_W(AW)) dut (
    .clock(clock), .i_reset(i_reset), .i_arm(i_arm), .i_abort(i_abort),
    .i_trigger(i_trigger), .i_capture_len(i_capture_len),
    .i_sample_valid(i_sample_valid), .i_sample(i_sample), .i_dump(i_dump),
    .o_ram_wr_addr(o_ram_wr_addr), .o_ram_wr_data(o_ram_wr_data), .o_ram_we(o_ram_we),
    .o_ram_rd_addr(o_ram_rd_addr), .o_ram_re(o_ram_re), .i_ram_rd_data(i_ram_rd_data),
    .o_dump_data(o_dump_data), .o_dump_valid(o_dump_valid), .i_dump_ready(i_dump_ready),
    .o_dump_last(o_dump_last), .o_busy(o_busy), .o_done(o_done), .o_count(o_count),
    .o_state(o_state)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Block RAM stand-in: synchronous write, registered read (1-cycle latency).
  logic [RW-1:0] ram [0:RD-1];
  int            n_wr = 0;
  int            cyc_n = 0;
  logic [AW-1:0] last_wr_addr = '0;
  always @(posedge clock) begin
    cyc_n <= cyc_n + 1;
    if (o_ram_we) begin
      if (int'(o_ram_wr_addr) < RD) ram[o_ram_wr_addr] <= o_ram_wr_data;
      n_wr         <= n_wr + 1;
      last_wr_addr <= o_ram_wr_addr;
    end
    if (o_ram_re && int'(o_ram_rd_addr) < RD) i_ram_rd_data <= ram[o_ram_rd_addr];
  end

  // ---------------- behavioural model ----------------
  // m_st uses the documented state codes; captured samples are kept in cap[].
  int            m_st = 0, m_cnt = 0, m_len = 0, m_rd = 0;
  bit            m_w;
  logic [RW-1:0] cap [0:RD-1];

  function automatic bit m_we();
    return i_sample_valid && !i_abort && (m_st == 2 || (m_st == 1 && i_trigger));
  endfunction

  initial forever begin
    @(posedge clock or negedge i_reset);
    if (!i_reset) begin
      m_st = 0; m_cnt = 0; m_len = 0; m_rd = 0;
    end else begin
      m_w = m_we();
      if (m_w) begin
        cap[m_cnt] = i_sample;
        m_cnt++;
      end
      if (i_abort) m_st = 0;
      else if (i_arm && (m_st == 0 || m_st == 3)) begin
        m_st  = 1;
        m_cnt = 0;
        m_len = (i_capture_len == 0 || int'(i_capture_len) > RD) ? RD : int'(i_capture_len);
      end
      else if (m_st == 1 && i_trigger) m_st = (m_w && m_cnt == m_len) ? 3 : 2;
      else if (m_st == 2 && m_w && m_cnt == m_len) m_st = 3;
      else if (m_st == 3 && i_dump) begin m_rd = 0; m_st = 4; end
      else if (m_st == 4 || m_st == 5) m_st++;
      else if (m_st == 6 && i_dump_ready) begin
        if (m_rd == m_cnt - 1) m_st = 3;
        else begin m_rd++; m_st = 4; end
      end
    end
  end

  // Per-cycle compare against the model (inputs are stable at the negedge).
  bit we_e;
  initial forever begin
    @(negedge clock);
    we_e = m_we();
    chk("state",    o_state, m_st);
    chk("count",    o_count, m_cnt);
    chk("busy",     o_busy, (m_st == 1 || m_st == 2 || m_st >= 4));
    chk("done",     o_done, m_st == 3);
    chk("we",       o_ram_we, we_e);
    chk("wr_addr",  o_ram_wr_addr, m_cnt);
    if (we_e) chk("wr_data", o_ram_wr_data, i_sample);
    chk("re",       o_ram_re, m_st == 4);
    chk("rd_addr",  o_ram_rd_addr, m_rd);
    chk("dvalid",   o_dump_valid, m_st == 6);
    chk("dlast",    o_dump_last, (m_st == 6 && m_rd == m_cnt - 1));
    if (m_st == 6) chk("ddata", o_dump_data, cap[m_rd]);
    if (!i_reset)  chk("ddata_rst", o_dump_data, 0);
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clock); #1; endtask

  task automatic idle_in();
    i_arm = 0; i_abort = 0; i_trigger = 0; i_sample_valid = 0; i_dump = 0;
  endtask

  task automatic arm(input logic [AW-1:0] len);
    i_capture_len = len; i_arm = 1; tick(); i_arm = 0;
  endtask

  logic [RW-1:0] got[$];
  int            got_last[$];
  int            acc_cyc[$];
  int            lat;

  task automatic dump_run(input bit toggle);
    bit rdy;
    int budget;
    got.delete(); got_last.delete(); acc_cyc.delete();
    rdy = 0;
    i_dump = 1; tick(); i_dump = 0;
    lat = 1;
    while (!o_dump_valid && lat < 10) begin tick(); lat++; end
    budget = 0;
    while (got.size() < 3 && budget < 60) begin
      i_dump_ready = toggle ? rdy : 1'b1;
      rdy = ~rdy;
      #1;
      if (o_dump_valid && i_dump_ready) begin
        got.push_back(o_dump_data);
        got_last.push_back(int'(o_dump_last));
        acc_cyc.push_back(cyc_n);
      end
      tick();
      budget++;
    end
    i_dump_ready = 0;
  endtask

  task automatic check_dump3();
    int lm;
    chk("dump_latency", lat, 3);
    chk("dump_nwords", got.size(), 3);
    for (int k = 0; k < 3; k++)
      chk("dump_word", (k < got.size()) ? got[k] : 32'hDEAD_BEEF, 32'hA0 + k);
    lm = 0;
    foreach (got_last[k]) if (got_last[k] != 0) lm |= (1 << k);
    chk("dump_last_pos", lm, 4);
  endtask

  task automatic clamp_run(input logic [AW-1:0] len);
    int n0, budget;
    i_abort = 1; tick(); i_abort = 0;
    arm(len);
    n0 = n_wr;
    i_trigger = 1; i_sample_valid = 1; i_sample = $urandom;
    budget = 0;
    while (!o_done && budget < 33000) begin
      tick();
      i_trigger = 0;
      i_sample = $urandom;
      budget++;
    end
    chk("clamp_done", o_done, 1);
    chk("clamp_nwr", n_wr - n0, 32000);
    chk("clamp_last_addr", last_wr_addr, 31999);
    chk("clamp_count", o_count, 32000);
    #1 chk("clamp_surplus_we", o_ram_we, 0);
    tick();
    idle_in();
  endtask

  initial begin
    int n0;
    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    chk("rst_state", o_state, 0);
    chk("rst_count", o_count, 0);
    chk("rst_we", o_ram_we, 0);
    chk("rst_re", o_ram_re, 0);
    chk("rst_ddata", o_dump_data, 0);
    chk("rst_busy", o_busy, 0);
    i_reset = 1;
    tick();

    // Basic capture, len=4, samples every other cycle.
    arm(4);
    chk("armed", o_state, 1);
    n0 = n_wr;
    for (int k = 0; k < 4; k++) begin
      i_trigger = (k == 0); i_sample_valid = 1; i_sample = 32'hA0 + k;
      tick();
      i_trigger = 0; i_sample_valid = 0;
      if (k < 3) tick();
    end
    chk("basic_done", o_done, 1);
    chk("basic_count", o_count, 4);
    i_sample_valid = 1; i_sample = 32'hA4;
    #1 chk("basic_5th_we", o_ram_we, 0);
    tick();
    idle_in();
    chk("basic_nwr", n_wr - n0, 4);
    for (int k = 0; k < 4; k++) chk("basic_ram", ram[k], 32'hA0 + k);

    // len=1 with trigger coincident with a sample.
    arm(1);
    i_trigger = 1; i_sample_valid = 1; i_sample = 32'h55;
    tick();
    idle_in();
    chk("len1_state", o_state, 3);
    chk("len1_count", o_count, 1);
    chk("len1_ram0", ram[0], 32'h55);

    // len=3 capture, then dump with backpressure, then again fully ready.
    arm(3);
    for (int k = 0; k < 3; k++) begin
      i_trigger = (k == 0); i_sample_valid = 1; i_sample = 32'hA0 + k;
      tick();
    end
    idle_in();
    chk("cap3_done", o_done, 1);
    dump_run(1'b1);
    check_dump3();
    dump_run(1'b0);
    check_dump3();
    if (acc_cyc.size() == 3) begin
      chk("thru_0_1", acc_cyc[1] - acc_cyc[0], 3);
      chk("thru_1_2", acc_cyc[2] - acc_cyc[1], 3);
    end else chk("thru_nwords", acc_cyc.size(), 3);

    // Abort together with arm while holding a readout word.
    i_dump = 1; tick(); i_dump = 0;
    begin
      int b = 0;
      while (!o_dump_valid && b < 10) begin tick(); b++; end
    end
    chk("hold_reached", o_dump_valid, 1);
    i_abort = 1; i_arm = 1; i_capture_len = 7;
    tick();
    idle_in();
    chk("abort_state", o_state, 0);
    chk("abort_dvalid", o_dump_valid, 0);
    chk("abort_count_kept", o_count, 3);

    // Arm during capture is ignored.
    arm(5);
    for (int k = 0; k < 2; k++) begin
      i_trigger = (k == 0); i_sample_valid = 1; i_sample = 32'h10 + k;
      tick();
    end
    i_trigger = 0;
    i_arm = 1; i_capture_len = 2; i_sample = 32'h12;
    #1 chk("arm_in_cap_addr", o_ram_wr_addr, 2);
    tick();
    i_arm = 0;
    for (int k = 3; k < 5; k++) begin i_sample = 32'h10 + k; tick(); end
    idle_in();
    chk("arm_in_cap_done", o_done, 1);
    chk("arm_in_cap_count", o_count, 5);

    // Asynchronous reset in the middle of a capture.
    arm(10);
    for (int k = 0; k < 5; k++) begin
      i_trigger = (k == 0); i_sample_valid = 1; i_sample = $urandom;
      tick();
    end
    i_trigger = 0;
    chk("pre_rst_count", o_count, 5);
    #2 i_reset = 0;
    #1;
    chk("arst_state", o_state, 0);
    chk("arst_we", o_ram_we, 0);
    chk("arst_count", o_count, 0);
    tick(); tick();
    i_reset = 1;
    n0 = n_wr;
    i_trigger = 1;
    repeat (5) tick();
    idle_in();
    chk("post_rst_no_write", n_wr - n0, 0);

    // Randomized traffic, short capture lengths.
    for (int c = 0; c < 2500; c++) begin
      i_arm          = ($urandom_range(0, 19) == 0);
      i_abort        = ($urandom_range(0, 63) == 0);
      i_trigger      = ($urandom_range(0, 3) == 0);
      i_sample_valid = 1'($urandom_range(0, 1));
      i_sample       = $urandom;
      i_capture_len  = AW'($urandom_range(1, 6));
      i_dump         = ($urandom_range(0, 3) == 0);
      i_dump_ready   = 1'($urandom_range(0, 1));
      tick();
    end
    idle_in();
    i_dump_ready = 0;
    tick();

    // Length clamp: 0 and above depth both capture exactly RAM_DEPTH samples.
    clamp_run(16'd0);
    clamp_run(16'd40000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
